// File: rtl/io_display_controller_if.sv
// CPU-side IN/OUT instruction handshake between the processor control and io_display_controller.
interface io_display_controller_if;
    logic        InReq;
    logic        OutReq;
    logic [31:0] OutData;
    logic [31:0] InData;
    logic        InAck;
    logic        Halt;

    modport master (
        output InReq, OutReq, OutData,
        input  InData, InAck, Halt
    );

    modport slave (
        input  InReq, OutReq, OutData,
        output InData, InAck, Halt
    );
endinterface

// File: rtl/io_display_controller.sv
// User-I/O sequencer: IN handshake with Enter, OUT display hold, register-monitor stepping,
// button debouncing and the registered display-value select.
module io_display_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned OUT_HOLD_CYCLES = 64,
    parameter int unsigned NUM_REGS        = 10
) (
    input  logic                    Clock,
    input  logic                    Reset,
    io_display_controller_if.slave  cpu,
    input  logic [31:0]             Switches,
    input  logic                    EnterBtn,
    input  logic                    SwapBtn,
    input  logic                    TypeSw,
    input  logic [31:0]             MonitorReg,
    output logic [4:0]              RegIndex,
    output logic [31:0]             DispValue,
    output logic [1:0]              DispSel
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_WAIT_IN,
        ST_ACK_IN,
        ST_SHOW_OUT
    } state_t;

    localparam int unsigned   CW        = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned   HW        = (OUT_HOLD_CYCLES > 1) ? $clog2(OUT_HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(OUT_HOLD_CYCLES - 1);
    localparam logic [4:0]    IDX_LAST  = 5'(NUM_REGS - 1);

    localparam logic [1:0] SEL_MONITOR = 2'd0;
    localparam logic [1:0] SEL_OUTPUT  = 2'd1;
    localparam logic [1:0] SEL_INPUT   = 2'd2;

    // Debouncers: bit 0 = Enter, bit 1 = Swap
    logic [1:0]    btn_raw;
    logic [1:0]    sync1_q, sync2_q, level_q, level_prev_q;
    logic [1:0]    press;
    logic [CW-1:0] cnt_q [2];

    assign btn_raw = {SwapBtn, EnterBtn};

    // The level flips on the DEBOUNCE_CYCLES-th consecutive cycle that disagrees with it.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            level_q      <= '0;
            level_prev_q <= '0;
            for (int unsigned i = 0; i < 2; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q      <= btn_raw;
            sync2_q      <= sync1_q;
            level_prev_q <= level_q;
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2_q[i] == level_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == DEB_LAST) begin
                    cnt_q[i]   <= '0;
                    level_q[i] <= sync2_q[i];
                end else begin
                    cnt_q[i] <= cnt_q[i] + CW'(1);
                end
            end
        end
    end

    assign press = level_q & ~level_prev_q;

    logic enter_press, swap_press;
    assign enter_press = press[0];
    assign swap_press  = press[1];

    state_t        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [31:0]   in_data_q, in_data_d;
    logic [31:0]   latch_q, latch_d;
    logic [4:0]    reg_idx_q, reg_idx_d;
    logic [31:0]   disp_value_q, disp_value_d;
    logic [1:0]    disp_sel_q, disp_sel_d;
    logic          halted;

    assign halted = (state_q == ST_WAIT_IN) || (state_q == ST_ACK_IN);

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        in_data_d    = in_data_q;
        latch_d      = latch_q;
        reg_idx_d    = reg_idx_q;
        disp_value_d = disp_value_q;
        disp_sel_d   = disp_sel_q;

        if (cpu.OutReq) latch_d = cpu.OutData;

        case (state_q)
            ST_RUN: begin
                if (cpu.InReq) begin
                    state_d = ST_WAIT_IN;
                end else if (cpu.OutReq) begin
                    hold_d  = HOLD_LOAD;
                    state_d = ST_SHOW_OUT;
                end
            end
            ST_WAIT_IN: begin
                if (enter_press) begin
                    in_data_d = Switches;
                    state_d   = ST_ACK_IN;
                end
            end
            ST_ACK_IN: state_d = ST_RUN;
            ST_SHOW_OUT: begin
                if (cpu.InReq) begin
                    state_d = ST_WAIT_IN;
                end else if (cpu.OutReq) begin
                    hold_d = HOLD_LOAD;
                end else if (swap_press || hold_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (swap_press && !halted) begin
            reg_idx_d = (reg_idx_q == IDX_LAST) ? '0 : reg_idx_q + 5'd1;
        end

        // Display follows the current state, so its output trails the state by one cycle.
        case (state_q)
            ST_WAIT_IN, ST_ACK_IN: begin
                disp_value_d = Switches;
                disp_sel_d   = SEL_INPUT;
            end
            ST_SHOW_OUT: begin
                disp_value_d = latch_q;
                disp_sel_d   = SEL_OUTPUT;
            end
            default: begin
                disp_value_d = TypeSw ? latch_q    : MonitorReg;
                disp_sel_d   = TypeSw ? SEL_OUTPUT : SEL_MONITOR;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q      <= ST_RUN;
            hold_q       <= '0;
            in_data_q    <= '0;
            latch_q      <= '0;
            reg_idx_q    <= '0;
            disp_value_q <= '0;
            disp_sel_q   <= SEL_MONITOR;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            in_data_q    <= in_data_d;
            latch_q      <= latch_d;
            reg_idx_q    <= reg_idx_d;
            disp_value_q <= disp_value_d;
            disp_sel_q   <= disp_sel_d;
        end
    end

    assign cpu.Halt   = halted;
    assign cpu.InAck  = (state_q == ST_ACK_IN);
    assign cpu.InData = in_data_q;
    assign RegIndex   = reg_idx_q;
    assign DispValue  = disp_value_q;
    assign DispSel    = disp_sel_q;

endmodule

// File: tb/tb_io_display_controller.sv
// Self-checking bench for io_display_controller with randomized data and a behavioural model.
module tb_io_display_controller;

    localparam int unsigned DEB  = 4;
    localparam int unsigned HOLD = 8;
    localparam int unsigned NREG = 10;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [31:0] Switches;
    logic        EnterBtn;
    logic        SwapBtn;
    logic        TypeSw;
    logic [31:0] MonitorReg;
    logic [4:0]  RegIndex;
    logic [31:0] DispValue;
    logic [1:0]  DispSel;

    io_display_controller_if cpu ();

    io_display_controller #(
        .DEBOUNCE_CYCLES (DEB),
        .OUT_HOLD_CYCLES (HOLD),
        .NUM_REGS        (NREG)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .cpu        (cpu),
        .Switches   (Switches),
        .EnterBtn   (EnterBtn),
        .SwapBtn    (SwapBtn),
        .TypeSw     (TypeSw),
        .MonitorReg (MonitorReg),
        .RegIndex   (RegIndex),
        .DispValue  (DispValue),
        .DispSel    (DispSel)
    );

    always #5 Clock = ~Clock;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] m_latch;
    int unsigned m_idx;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) tick();
    endtask

    // Drives one Enter press (held 10 cycles) and observes the CPU handshake for 30 cycles.
    task automatic press_enter(output int acks, output int first_at, output logic [31:0] data_at,
                               output int halt_after, output int halt_total);
        acks = 0; first_at = 0; data_at = '0; halt_after = 0; halt_total = 0;
        EnterBtn = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            if (i == 11) EnterBtn = 1'b0;
            tick();
            if (cpu.Halt === 1'b1) halt_total++;
            if (cpu.InAck === 1'b1) begin
                acks++;
                if (first_at == 0) begin
                    first_at = i;
                    data_at  = cpu.InData;
                end
            end else if (first_at != 0 && cpu.Halt !== 1'b0) begin
                halt_after++;
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0; TypeSw = 1'b0; MonitorReg = 32'h1234;
        idle(3);
        n_checks++; if (DispValue !== 32'h0) begin n_fail++; $display("FAIL reset_disp: got %h want %h", DispValue, 32'h0); end
        n_checks++; if (cpu.Halt !== 1'b0) begin n_fail++; $display("FAIL reset_halt: got %b want 0", cpu.Halt); end
        n_checks++; if (cpu.InAck !== 1'b0) begin n_fail++; $display("FAIL reset_inack: got %b want 0", cpu.InAck); end
        n_checks++; if (cpu.InData !== 32'h0) begin n_fail++; $display("FAIL reset_indata: got %h want 0", cpu.InData); end
        Reset = 1'b1;
        tick();
        n_checks++; if (DispValue !== 32'h1234) begin n_fail++; $display("FAIL post_reset_disp: got %h want %h", DispValue, 32'h1234); end
        n_checks++; if (DispSel !== 2'd0) begin n_fail++; $display("FAIL post_reset_sel: got %0d want 0", DispSel); end
        n_checks++; if (cpu.Halt !== 1'b0) begin n_fail++; $display("FAIL post_reset_halt: got %b want 0", cpu.Halt); end
        n_checks++; if (RegIndex !== 5'd0) begin n_fail++; $display("FAIL post_reset_idx: got %0d want 0", RegIndex); end
        m_latch = '0; m_idx = 0;
    endtask

    task automatic test_swap_steps();
        logic [31:0] mon;
        for (int k = 1; k <= 10; k++) begin
            SwapBtn = 1'b1; idle($urandom_range(10, 13));
            SwapBtn = 1'b0; idle($urandom_range(10, 13));
            m_idx = (m_idx + 1) % NREG;
            n_checks++; if (RegIndex !== 5'(m_idx)) begin n_fail++; $display("FAIL swap_step%0d: got %0d want %0d", k, RegIndex, m_idx); end
            mon = $urandom; MonitorReg = mon;
            tick();
            n_checks++; if (DispValue !== mon || DispSel !== 2'd0) begin n_fail++; $display("FAIL monitor_disp%0d: got %h/%0d want %h/0", k, DispValue, DispSel, mon); end
        end
        SwapBtn = 1'b1; idle(2);
        SwapBtn = 1'b0; idle(10);
        n_checks++; if (RegIndex !== 5'(m_idx)) begin n_fail++; $display("FAIL swap_glitch: got %0d want %0d", RegIndex, m_idx); end
    endtask

    task automatic test_in_handshake(input logic [31:0] sw);
        int acks, first_at, halt_after, halt_total, early_acks;
        logic [31:0] data_at;
        Switches = sw;
        cpu.InReq = 1'b1; tick(); cpu.InReq = 1'b0;
        n_checks++; if (cpu.Halt !== 1'b1) begin n_fail++; $display("FAIL in_halt_rise: got %b want 1", cpu.Halt); end
        tick();
        n_checks++; if (DispSel !== 2'd2 || DispValue !== sw) begin n_fail++; $display("FAIL in_disp: got %h/%0d want %h/2", DispValue, DispSel, sw); end
        // Swap presses while halted must be dropped; no ack may appear before Enter.
        early_acks = 0;
        SwapBtn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) SwapBtn = 1'b0;
            tick();
            if (cpu.InAck === 1'b1) early_acks++;
        end
        n_checks++; if (early_acks != 0) begin n_fail++; $display("FAIL in_early_ack: got %0d want 0", early_acks); end
        n_checks++; if (RegIndex !== 5'(m_idx)) begin n_fail++; $display("FAIL in_swap_ignored: got %0d want %0d", RegIndex, m_idx); end
        n_checks++; if (cpu.Halt !== 1'b1) begin n_fail++; $display("FAIL in_halt_hold: got %b want 1", cpu.Halt); end
        press_enter(acks, first_at, data_at, halt_after, halt_total);
        n_checks++; if (acks != 1) begin n_fail++; $display("FAIL in_ack_count: got %0d want 1", acks); end
        n_checks++; if (first_at < 5 || first_at > 9) begin n_fail++; $display("FAIL in_ack_latency: got %0d want 5..9", first_at); end
        n_checks++; if (data_at !== sw) begin n_fail++; $display("FAIL in_data: got %h want %h", data_at, sw); end
        n_checks++; if (halt_after != 0) begin n_fail++; $display("FAIL in_halt_after_ack: got %0d want 0", halt_after); end
        n_checks++; if (halt_total != first_at) begin n_fail++; $display("FAIL in_halt_span: got %0d want %0d", halt_total, first_at); end
        Switches = ~sw; tick();
        n_checks++; if (cpu.InData !== sw) begin n_fail++; $display("FAIL in_data_hold: got %h want %h", cpu.InData, sw); end
    endtask

    task automatic test_enter_outside();
        int acks, first_at, halt_after, halt_total;
        logic [31:0] data_at;
        press_enter(acks, first_at, data_at, halt_after, halt_total);
        n_checks++; if (acks != 0) begin n_fail++; $display("FAIL enter_run_ack: got %0d want 0", acks); end
        n_checks++; if (halt_total != 0) begin n_fail++; $display("FAIL enter_run_halt: got %0d want 0", halt_total); end
        test_in_handshake($urandom);
    endtask

    // Model: display shows the output latch while any OutReq was taken within the last HOLD edges.
    task automatic test_out_hold();
        int last_req = -1000;
        logic req;
        logic [31:0] data, mon, exp_v;
        logic [1:0] exp_s;
        for (int t = 1; t <= 120; t++) begin
            data = $urandom; mon = $urandom;
            if (t == 1) begin req = 1'b1; data = 32'h00FF; end
            else if (t == 15 || t == 19) req = 1'b1;
            else if (t <= 30) req = 1'b0;
            else req = ($urandom_range(0, 9) == 0);
            cpu.OutReq = req; cpu.OutData = data; MonitorReg = mon;
            TypeSw = (t <= 30) ? 1'b0 : 1'($urandom_range(0, 1));
            if (t - last_req <= int'(HOLD)) begin exp_v = m_latch; exp_s = 2'd1; end
            else if (TypeSw) begin exp_v = m_latch; exp_s = 2'd1; end
            else begin exp_v = mon; exp_s = 2'd0; end
            tick();
            n_checks++; if (DispValue !== exp_v || DispSel !== exp_s) begin n_fail++; $display("FAIL out_disp t=%0d: got %h/%0d want %h/%0d", t, DispValue, DispSel, exp_v, exp_s); end
            if (cpu.Halt !== 1'b0) begin n_fail++; $display("FAIL out_halt t=%0d: got %b want 0", t, cpu.Halt); end
            n_checks++;
            if (req) begin last_req = t; m_latch = data; end
        end
        cpu.OutReq = 1'b0; TypeSw = 1'b0;
        idle(HOLD + 2);
    endtask

    task automatic test_simultaneous();
        int acks, first_at, halt_after, halt_total;
        logic [31:0] data_at, mon;
        TypeSw = 1'b0;
        cpu.InReq = 1'b1; cpu.OutReq = 1'b1; cpu.OutData = 32'h55;
        tick();
        cpu.InReq = 1'b0; cpu.OutReq = 1'b0;
        m_latch = 32'h55;
        n_checks++; if (cpu.Halt !== 1'b1) begin n_fail++; $display("FAIL sim_halt: got %b want 1", cpu.Halt); end
        tick();
        n_checks++; if (DispSel !== 2'd2) begin n_fail++; $display("FAIL sim_sel: got %0d want 2", DispSel); end
        press_enter(acks, first_at, data_at, halt_after, halt_total);
        n_checks++; if (acks != 1) begin n_fail++; $display("FAIL sim_ack_count: got %0d want 1", acks); end
        TypeSw = 1'b1; tick();
        n_checks++; if (DispValue !== m_latch || DispSel !== 2'd1) begin n_fail++; $display("FAIL sim_typesw: got %h/%0d want %h/1", DispValue, DispSel, m_latch); end
        TypeSw = 1'b0; mon = $urandom; MonitorReg = mon; tick();
        n_checks++; if (DispValue !== mon || DispSel !== 2'd0) begin n_fail++; $display("FAIL sim_monitor: got %h/%0d want %h/0", DispValue, DispSel, mon); end
    endtask

    task automatic test_reset_mid_wait();
        int acks, first_at, halt_after, halt_total;
        logic [31:0] data_at;
        SwapBtn = 1'b1; idle(10); SwapBtn = 1'b0; idle(10);
        m_idx = (m_idx + 1) % NREG;
        n_checks++; if (RegIndex !== 5'(m_idx)) begin n_fail++; $display("FAIL pre_reset_idx: got %0d want %0d", RegIndex, m_idx); end
        cpu.InReq = 1'b1; tick(); cpu.InReq = 1'b0;
        idle(3);
        n_checks++; if (cpu.Halt !== 1'b1) begin n_fail++; $display("FAIL rst_wait_halt: got %b want 1", cpu.Halt); end
        #2 Reset = 1'b0;
        #1;
        n_checks++; if (cpu.Halt !== 1'b0) begin n_fail++; $display("FAIL rst_async_halt: got %b want 0", cpu.Halt); end
        n_checks++; if (DispSel !== 2'd0 || RegIndex !== 5'd0) begin n_fail++; $display("FAIL rst_async_regs: got sel %0d idx %0d want 0/0", DispSel, RegIndex); end
        m_idx = 0; m_latch = '0;
        idle(2);
        Reset = 1'b1;
        press_enter(acks, first_at, data_at, halt_after, halt_total);
        n_checks++; if (acks != 0 || halt_total != 0) begin n_fail++; $display("FAIL rst_no_ack: got acks %0d halt %0d want 0/0", acks, halt_total); end
        TypeSw = 1'b1; tick();
        n_checks++; if (DispValue !== m_latch || DispSel !== 2'd1) begin n_fail++; $display("FAIL rst_latch: got %h/%0d want %h/1", DispValue, DispSel, m_latch); end
        TypeSw = 1'b0;
    endtask

    initial begin
        Reset = 1'b0; Switches = '0; EnterBtn = 1'b0; SwapBtn = 1'b0; TypeSw = 1'b0; MonitorReg = '0;
        cpu.InReq = 1'b0; cpu.OutReq = 1'b0; cpu.OutData = '0;
        m_latch = '0; m_idx = 0;
        test_reset();
        test_swap_steps();
        test_in_handshake(32'hCAFE);
        test_enter_outside();
        test_out_hold();
        test_simultaneous();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/io_display_controller.md
Name: io_display_controller

Overview:
- Sequences the processor's user-I/O path: input-instruction handshake (halt CPU, wait for Enter, return switch value), output-value display hold, and register-monitor index stepping.
- Owns button debouncing and selects the 32-bit value driven to the Bin2BCD/7-segment display chain.
- Sits between CPU control (IN/OUT instruction signals, register-file monitor port) and the board switches, buttons and displays.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable cycles before a debounced button level changes (board build uses 500000).
- OUT_HOLD_CYCLES, 64, cycles an OUT value is forced onto the display.
- NUM_REGS, 10, number of monitorable registers; RegIndex wraps at NUM_REGS-1.

Ports:
- Clock  input  1  system clock, all logic on rising edge.
- Reset  input  1  asynchronous active-low reset.
- InReq  input  1  one-cycle pulse: CPU executing IN.
- OutReq  input  1  one-cycle pulse: CPU executing OUT; OutData valid the same cycle.
- OutData  input  32  value written by OUT.
- Switches  input  32  board switch value (DataIO).
- EnterBtn  input  1  raw Enter button, active high, asynchronous to Clock.
- SwapBtn  input  1  raw register-step button, active high, asynchronous to Clock.
- TypeSw  input  1  0 = show monitored register, 1 = show last output (RUN only).
- MonitorReg  input  32  register-file read data for RegIndex.
- RegIndex  output  5  register number being monitored.
- InData  output  32  captured switch value returned to CPU.
- InAck  output  1  one-cycle pulse: InData valid, IN complete.
- Halt  output  1  CPU stall request; also drives the halt display digit.
- DispValue  output  32  value to the Bin2BCD/display chain.
- DispSel  output  2  0 = monitor, 1 = output, 2 = input; 3 is never driven.

Behaviour:
- Reset (Reset=0), asynchronous: state RUN; RegIndex, InData, output latch, DispValue and DispSel = 0; InAck = 0; Halt = 0; debouncers hold level 0 with their counters cleared.
- Debounce, one per button:
  - 2-flop synchronizer, then a counter.
  - Counter clears whenever the synchronized raw value equals the debounced level; otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the raw value.
  - A 0->1 transition of the debounced level produces exactly one press-pulse cycle.
- Output latch: on any cycle with OutReq=1, the latch takes OutData, in every state.
- State RUN:
  - Halt=0.
  - If InReq, go to WAIT_IN. Else if OutReq, load the hold counter with OUT_HOLD_CYCLES-1 and go to SHOW_OUT.
  - InReq wins if both are asserted; the OutReq latch update still occurs.
- State WAIT_IN:
  - Halt=1.
  - On an Enter press: InData<=Switches, go to ACK_IN.
  - Further InReq/OutReq are ignored for state purposes; a well-formed CPU is stalled.
- State ACK_IN: InAck=1 and Halt=1 for exactly this cycle, then go to RUN.
- State SHOW_OUT:
  - Halt=0; the hold counter decrements each cycle.
  - InReq goes to WAIT_IN (highest priority).
  - Else a new OutReq reloads the counter and stays in SHOW_OUT.
  - Else a Swap press, or counter==0, goes to RUN.
- Display mux, registered with 1-cycle latency; DispValue/DispSel reflect the state of the previous cycle:
  - WAIT_IN or ACK_IN: Switches, sel 2.
  - SHOW_OUT: output latch, sel 1.
  - RUN: TypeSw ? latch,1 : MonitorReg,0.
- RegIndex:
  - A Swap press increments it in any state except WAIT_IN/ACK_IN, where presses are discarded.
  - Value NUM_REGS-1 wraps to 0. Width fixed at 5 bits; NUM_REGS must be in 1..32.
- An Enter press outside WAIT_IN is discarded; no press is queued.
- Reset mid-WAIT_IN: Halt drops immediately (asynchronously) and no InAck is issued.

Test Plan:
- Bench uses DEBOUNCE_CYCLES=4, OUT_HOLD_CYCLES=8, NUM_REGS=10.
- Reset release, TypeSw=0, MonitorReg=0x1234 -> next cycle DispValue=0x1234, DispSel=0, Halt=0, RegIndex=0.
- Ten clean Swap presses, each held 10 cycles -> RegIndex steps 1..9 then 0. A 2-cycle glitch between presses -> no increment.
- IN handshake:
  - Stimulus: InReq pulse, Switches=0xCAFE; Enter pressed 20 cycles later and held 10 cycles.
  - Required: Halt=1 from the cycle after InReq; DispSel=2. InAck high exactly one cycle, about 6 cycles after the Enter edge (2-cycle synchronizer plus 4-cycle debounce), with InData=0xCAFE; Halt=0 the following cycle.
- OUT hold: OutReq with OutData=0x00FF, TypeSw=0 -> DispValue=0x00FF, DispSel=1 for 8 cycles, then DispValue=MonitorReg. A second OutReq mid-hold restarts the 8-cycle window.
- Simultaneous InReq+OutReq(0x55) in RUN -> WAIT_IN entered. Later TypeSw=1 in RUN -> DispValue=0x55.
- Reset asserted while in WAIT_IN -> Halt=0 immediately, InAck never pulses, state RUN after release.
